alu_ctrl_seq: RTL
=================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter OP_W, default 3: ALUOp width in bits.
REQ-002 Parameter MD_CYCLES, default 32: busy cycles for one multiply/divide operation, legal range 2..255.
REQ-003 Port clk, input, 1: sole clock; all logic updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port in_valid, input, 1: ALUOp/funct presented this cycle.
REQ-006 Port in_ready, output, 1: block accepts a request this cycle.
REQ-007 Port ALUOp, input, OP_W: main-decoder operation class.
REQ-008 Port funct, input, 6: R-type function field.
REQ-009 Port out_valid, output, 1: ALUCnt/illegal hold a decoded request.
REQ-010 Port ALUCnt, output, 4: registered ALU control code.
REQ-011 Port illegal, output, 1: decoded request unsupported.
REQ-012 Port md_busy, output, 1: multi-cycle multiply/divide in progress.
REQ-013 Port md_done, output, 1: one-cycle pulse, multiply/divide complete.

Function
REQ-014 Accept: a transfer occurs when in_valid=1 and in_ready=1 at a rising edge.
REQ-015 in_ready = 1 in IDLE, 0 in BUSY and in DONE.
REQ-016 ALUOp decode: 0 → funct table; 1 → 0010; 2 → 0110; 3 → 0000; 4 → 0001; 5 → 0111; any other value → 0010.
REQ-017 Funct table (ALUOp=0): 0x20 → 0010; 0x22 → 0110; 0x24 → 0000; 0x25 → 0001; 0x27 → 1100; 0x2A → 0111; 0x00 → 0011; 0x02 → 0100; 0x18 → 1000 (mult); 0x1A → 1001 (div).
REQ-018 Any other funct with ALUOp=0 decodes to ALUCnt=1111 and illegal=1.
REQ-019 Latency: on an accept, ALUCnt, illegal and out_valid=1 are registered at that edge and visible the following cycle.
REQ-020 A cycle without an accept clears out_valid to 0; ALUCnt and illegal hold their last values.
REQ-021 FSM states are IDLE, BUSY and DONE.
REQ-022 IDLE → BUSY on accept of code 1000 or 1001; the counter loads MD_CYCLES-1 and md_busy=1.
REQ-023 In BUSY the counter decrements by 1 per cycle; when it reaches 0 the FSM moves to DONE at the next edge, giving exactly MD_CYCLES cycles of md_busy=1.
REQ-024 DONE lasts exactly one cycle: md_done=1, md_busy=0, in_ready=0, then → IDLE.
REQ-025 Requests with in_valid=1 during BUSY or DONE are not accepted and cause no state change; the requester holds them.
REQ-026 An illegal request does not enter BUSY.
REQ-027 Counter width is 8 bits; the counter never wraps below 0.

Reset
REQ-028 When rst_n=0 at a rising edge, the block enters IDLE with: counter=0, out_valid=0, ALUCnt=0000, illegal=0, md_busy=0, md_done=0, in_ready=1 from the next cycle.
REQ-029 Reset during BUSY or DONE abandons the operation; no md_done pulse is produced.
REQ-030 Reset takes priority over a simultaneous in_valid; that request is not accepted.

Configuration
REQ-031 Macro ALU_CTRL_DIV_EN defined: funct 0x1A decodes to 1001 and runs the BUSY sequence.
REQ-032 Macro ALU_CTRL_DIV_EN undefined: funct 0x1A decodes to 1111 with illegal=1, no BUSY entry, and no divide logic is synthesised.

Verification
REQ-033 Reset, then ALUOp=1, in_valid=1 for one cycle → next cycle out_valid=1, ALUCnt=0010, illegal=0; the cycle after, out_valid=0.
REQ-034 ALUOp=0, funct sweeping 0x20, 0x22, 0x24, 0x25, 0x27, 0x2A, 0x00, 0x02 back-to-back → ALUCnt 0010, 0110, 0000, 0001, 1100, 0111, 0011, 0100, each one cycle after its input.
REQ-035 ALUOp=0, funct=0x05 → ALUCnt=1111, illegal=1, md_busy stays 0.
REQ-036 MD_CYCLES=4, funct=0x18, in_valid held high → md_busy=1 for 4 cycles, md_done=1 for 1 cycle, in_ready=0 for 5 cycles, next request accepted on the first IDLE cycle.
REQ-037 funct=0x1A with ALU_CTRL_DIV_EN defined → ALUCnt=1001 and the BUSY sequence runs; without the macro → ALUCnt=1111, illegal=1.
REQ-038 rst_n=0 in the 2nd BUSY cycle → next cycle md_busy=0, in_ready=1, md_done never asserted.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with a registered output stage and a multi-cycle multiply/divide sequencer.
// Define ALU_CTRL_DIV_EN to enable the divide code (funct 0x1A); without it, 0x1A is illegal.
module alu_ctrl_seq #(
    parameter int OP_W      = 3,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] ALUOp,
    input  logic [5:0]      funct,
    output logic            out_valid,
    output logic [3:0]      ALUCnt,
    output logic            illegal,
    output logic            md_busy,
    output logic            md_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CODE_MULT = 4'b1000;
    localparam logic [3:0] CODE_DIV  = 4'b1001;
    localparam logic [3:0] CODE_BAD  = 4'b1111;
    localparam logic [7:0] CNT_LOAD  = 8'(MD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] alu_cnt_q, alu_cnt_d;
    logic       illegal_q, illegal_d;
    logic       md_busy_q, md_busy_d;
    logic       md_done_q, md_done_d;

    logic [31:0] op_ext;
    logic [3:0]  dec_code;
    logic        dec_illegal;
    logic        dec_md;
    logic        accept;

    assign op_ext = 32'(ALUOp);
    assign accept = in_valid && in_ready_q;

    always_comb begin
        dec_code    = 4'b0010;
        dec_illegal = 1'b0;
        if (op_ext == 32'd0) begin
            case (funct)
                6'h20:   dec_code = 4'b0010;
                6'h22:   dec_code = 4'b0110;
                6'h24:   dec_code = 4'b0000;
                6'h25:   dec_code = 4'b0001;
                6'h27:   dec_code = 4'b1100;
                6'h2A:   dec_code = 4'b0111;
                6'h00:   dec_code = 4'b0011;
                6'h02:   dec_code = 4'b0100;
                6'h18:   dec_code = CODE_MULT;
`ifdef ALU_CTRL_DIV_EN
                6'h1A:   dec_code = CODE_DIV;
`endif
                default: begin
                    dec_code    = CODE_BAD;
                    dec_illegal = 1'b1;
                end
            endcase
        end else begin
            case (op_ext)
                32'd1:   dec_code = 4'b0010;
                32'd2:   dec_code = 4'b0110;
                32'd3:   dec_code = 4'b0000;
                32'd4:   dec_code = 4'b0001;
                32'd5:   dec_code = 4'b0111;
                default: dec_code = 4'b0010;
            endcase
        end
    end

    // Only the funct path can produce the multi-cycle codes, so no illegal gating is needed here.
    always_comb begin
`ifdef ALU_CTRL_DIV_EN
        dec_md = (dec_code == CODE_MULT) || (dec_code == CODE_DIV);
`else
        dec_md = (dec_code == CODE_MULT);
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = accept;
        alu_cnt_d   = alu_cnt_q;
        illegal_d   = illegal_q;
        if (accept) begin
            alu_cnt_d = dec_code;
            illegal_d = dec_illegal;
        end
        case (state_q)
            IDLE: begin
                if (accept && dec_md) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        // Status outputs follow the next state so they are registered alongside it.
        in_ready_d = (state_d == IDLE);
        md_busy_d  = (state_d == BUSY);
        md_done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            alu_cnt_q   <= 4'b0000;
            illegal_q   <= 1'b0;
            md_busy_q   <= 1'b0;
            md_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            alu_cnt_q   <= alu_cnt_d;
            illegal_q   <= illegal_d;
            md_busy_q   <= md_busy_d;
            md_done_q   <= md_done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ALUCnt    = alu_cnt_q;
    assign illegal   = illegal_q;
    assign md_busy   = md_busy_q;
    assign md_done   = md_done_q;

endmodule
